// File: rtl/seqdec_pkg.sv
// Shared definitions for the seqdec_28 detector and its byte serializer front end.
package seqdec_pkg;

  localparam int BYTE_W = 8;

  // Pattern recognised by the downstream seqdec_28 detector.
  localparam logic [BYTE_W-1:0] SEQ_PATTERN = 8'h28;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/seqdec_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; occupancy is the pointer difference.
module seqdec_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit tells full from empty when the index bits match.
  assign count   = wptr - rptr;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW + 1)'(1);
      if (do_pop)  rptr <= rptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push && !Reset) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/seqdec_byte_ser.sv
// Byte-to-bit serializer feeding the seqdec_28 detector: buffered bytes leave
// MSB-first, one bit per clock, with no gap between consecutive bytes.
module seqdec_byte_ser
  import seqdec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [BYTE_W-1:0]      DataIn,
  input  logic                   InValid,
  output logic                   InReady,
  output logic                   SerOut,
  output logic                   SerValid,
  output logic                   Busy,
  output logic [$clog2(DEPTH):0] Level
);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_SHIFT = SHIFT;

  logic [0:0]            state;
  logic [BYTE_W-1:0]     shreg;
  logic [2:0]            bitcnt;
  logic [BYTE_W-1:0]     fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  push;
  logic                  load;

  assign push = InValid && !fifo_full;

  // A new byte is taken either from idle or on the last bit of the current one,
  // which is what keeps back-to-back bytes gapless.
  assign load = !fifo_empty && ((state == ST_IDLE) || (bitcnt == 3'd7));

  seqdec_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .wdata (DataIn),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else if (state == ST_IDLE) begin
      if (load) begin
        state  <= ST_SHIFT;
        shreg  <= fifo_rdata;
        bitcnt <= '0;
      end
    end else if (bitcnt != 3'd7) begin
      shreg  <= {shreg[BYTE_W-2:0], 1'b0};
      bitcnt <= bitcnt + 3'd1;
    end else if (load) begin
      shreg  <= fifo_rdata;
      bitcnt <= '0;
    end else begin
      state <= ST_IDLE;
    end
  end

  assign InReady  = !fifo_full;
  assign SerValid = (state == ST_SHIFT);
  assign SerOut   = (state == ST_SHIFT) && shreg[BYTE_W-1];
  assign Busy     = (state == ST_SHIFT) || !fifo_empty;
  assign Level    = fifo_count;

endmodule

// File: tb/tb_seqdec_byte_ser.sv
// Self-checking bench for seqdec_byte_ser: reference vectors, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_seqdec_byte_ser;
  import seqdec_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          Clk;
  logic          Reset;
  logic [7:0]    DataIn;
  logic          InValid;
  logic          InReady;
  logic          SerOut;
  logic          SerValid;
  logic          Busy;
  logic [LW-1:0] Level;

  int total = 0;
  int bad   = 0;
  int edgeNo;
  int runLen, maxRun, peakLevel;
  bit mAccept;

  logic [7:0] mFifo[$];
  bit         mBits[$];
  bit         streamQ[$];
  int         acceptEdges[$];
  logic [7:0] pendQ[$];
  logic [7:0] expQ[$];

  typedef struct {
    bit         rst;
    bit         valid;
    logic [7:0] data;
    bit         eReady;
    bit         eOut;
    bit         eVal;
    bit         eBusy;
    int         eLevel;
  } vec_t;

  vec_t vecs[12];

  seqdec_byte_ser #(.DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .DataIn   (DataIn),
    .InValid  (InValid),
    .InReady  (InReady),
    .SerOut   (SerOut),
    .SerValid (SerValid),
    .Busy     (Busy),
    .Level    (Level)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue plus the bits of the byte currently on the line.
  task automatic modelStep(input bit rst, input logic [7:0] data);
    logic [7:0] b;
    if (rst) begin
      mFifo.delete();
      mBits.delete();
    end else begin
      if (mBits.size() > 1) void'(mBits.pop_front());
      else begin
        mBits.delete();
        if (mFifo.size() > 0) begin
          b = mFifo.pop_front();
          for (int k = 7; k >= 0; k--) mBits.push_back(b[k]);
        end
      end
      if (mAccept) mFifo.push_back(data);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit valid, input logic [7:0] data);
    Reset   = rst;
    InValid = valid;
    DataIn  = data;
    if (!rst && valid && InReady === 1'b1) acceptEdges.push_back(edgeNo);
    mAccept = !rst && valid && (mFifo.size() < DEPTH);
    @(posedge Clk);
    #1;
    edgeNo++;
    modelStep(rst, data);
    if (SerValid === 1'b1) begin
      streamQ.push_back(SerOut);
      runLen++;
      if (runLen > maxRun) maxRun = runLen;
    end else begin
      runLen = 0;
    end
    if (int'(Level) > peakLevel) peakLevel = int'(Level);
  endtask

  task automatic checkOutput(input string name, input bit eReady, input bit eOut,
                             input bit eVal, input bit eBusy, input int eLevel);
    compareVal({name, ".InReady"},  InReady,  eReady);
    compareVal({name, ".SerOut"},   SerOut,   eOut);
    compareVal({name, ".SerValid"}, SerValid, eVal);
    compareVal({name, ".Busy"},     Busy,     eBusy);
    compareVal({name, ".Level"},    Level,    eLevel);
  endtask

  task automatic checkModel(input string name);
    bit mv;
    mv = (mBits.size() > 0);
    checkOutput(name, mFifo.size() != DEPTH, mv ? mBits[0] : 1'b0, mv,
                mv || (mFifo.size() != 0), mFifo.size());
  endtask

  task automatic startSeq();
    streamQ.delete();
    acceptEdges.delete();
    expQ.delete();
    runLen    = 0;
    maxRun    = 0;
    peakLevel = 0;
    edgeNo    = 0;
  endtask

  task automatic drainPending(input string name, input int budget);
    int         cyc;
    bit         v;
    logic [7:0] d;
    cyc = 0;
    while ((pendQ.size() > 0 || mBits.size() > 0 || mFifo.size() > 0) && cyc < budget) begin
      v = (pendQ.size() > 0);
      d = v ? pendQ[0] : 8'h00;
      applyStimulus(1'b0, v, d);
      if (mAccept) void'(pendQ.pop_front());
      checkModel(name);
      cyc++;
    end
    if (pendQ.size() > 0 || mBits.size() > 0 || mFifo.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s.timeout: still busy after %0d cycles, required idle", name, budget);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkModel(name);
  endtask

  task automatic checkStream(input string name);
    int mism;
    bit e;
    mism = 0;
    compareVal({name, ".len"}, streamQ.size(), expQ.size() * 8);
    for (int i = 0; i < expQ.size() * 8; i++) begin
      e = expQ[i / 8][7 - (i % 8)];
      if (i >= streamQ.size()) mism++;
      else if (streamQ[i] !== e) mism++;
    end
    compareVal({name, ".bitErrs"}, mism, 0);
  endtask

  function automatic int countPattern();
    logic [7:0] w;
    int hits;
    w    = 8'h00;
    hits = 0;
    foreach (streamQ[i]) begin
      w = {w[6:0], streamQ[i]};
      if (i >= 7 && w == SEQ_PATTERN) hits++;
    end
    return hits;
  endfunction

  function automatic logic [63:0] packStream(input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < streamQ.size(); i++) v = {v[62:0], streamQ[i]};
    return v;
  endfunction

  initial begin
    Reset   = 1'b1;
    InValid = 1'b0;
    DataIn  = 8'h00;
    edgeNo  = 0;

    // Reset for two cycles, then one 0x28 byte: 0,0,1,0,1,0,0,0 after E1..E8.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 8'h28, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0};

    startSeq();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].eReady, vecs[i].eOut,
                  vecs[i].eVal, vecs[i].eBusy, vecs[i].eLevel);
    end
    expQ.push_back(8'h28);
    checkStream("single");
    compareVal("single.run", maxRun, 8);
    compareVal("single.detHits", countPattern(), 1);

    startSeq();
    pendQ = '{8'h85, 8'h97, 8'h42, 8'h53, 8'h28};
    expQ  = '{8'h85, 8'h97, 8'h42, 8'h53, 8'h28};
    drainPending("b2b", 200);
    checkStream("b2b");
    compareVal("b2b.word", packStream(40), 64'h85_9742_5328);
    compareVal("b2b.run", maxRun, 40);
    compareVal("b2b.peakLevel", peakLevel, 4);
    compareVal("b2b.accepts", acceptEdges.size(), 5);
    if (acceptEdges.size() == 5) compareVal("b2b.lastAcceptEdge", acceptEdges[4], 4);

    startSeq();
    pendQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    expQ  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    drainPending("full", 300);
    checkStream("full");
    compareVal("full.run", maxRun, 48);
    compareVal("full.peakLevel", peakLevel, 4);
    compareVal("full.accepts", acceptEdges.size(), 6);
    if (acceptEdges.size() == 6) compareVal("full.stallAcceptEdge", acceptEdges[5], 10);

    startSeq();
    applyStimulus(1'b0, 1'b1, 8'hA5);
    checkModel("rstmid");
    applyStimulus(1'b0, 1'b1, 8'h3C);
    checkModel("rstmid");
    applyStimulus(1'b0, 1'b1, 8'hC3);
    checkModel("rstmid");
    compareVal("rstmid.queued", Level, 2);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkModel("rstmid");
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkModel("rstmid");
    compareVal("rstmid.partial", packStream(4), 64'hA);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("rstmid.after", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkModel("rstmid.quiet");
    end
    compareVal("rstmid.bitsSeen", streamQ.size(), 4);

    startSeq();
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      pendQ.push_back(8'h30 + 8'(i));
      expQ.push_back(8'h30 + 8'(i));
    end
    drainPending("wrap", 400);
    checkStream("wrap");
    compareVal("wrap.run", maxRun, (3 * DEPTH + 1) * 8);

    startSeq();
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55, 8'($urandom));
      checkModel("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seqdec_byte_ser.md
# seqdec_byte_ser

Upstream feeder for the `seqdec_28` serial sequence detector. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. Each byte is shifted out MSB-first, one bit per clock, onto a serial line that drives the detector's `InA` input. Consecutive buffered bytes are emitted back-to-back with no gap bits, so multi-byte patterns reach the detector contiguously.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.

Ports:
- `Clk`: input, 1 bit. Clock.
- `Reset`: input, 1 bit. Reset, synchronous, active-high. Clock is `Clk`.
- `DataIn`: input, 8 bits. Byte to serialize.
- `InValid`: input, 1 bit. `DataIn` is valid.
- `InReady`: output, 1 bit. FIFO can accept a byte.
- `SerOut`: output, 1 bit. Serial bit; connects to detector `InA`.
- `SerValid`: output, 1 bit. `SerOut` carries a real data bit.
- `Busy`: output, 1 bit. Shifter active or FIFO non-empty.
- `Level`: output, clog2(DEPTH)+1 bits. FIFO occupancy; excludes the byte currently in the shifter.

## Operation
- Push: occurs when `InValid && InReady` at a rising edge. `InReady = (Level != DEPTH)`, registered-count based.
  - There is no same-cycle bypass: a pop in the same cycle does not raise `InReady`.
- Shifter states:
  - IDLE: `SerOut=0`, `SerValid=0`.
  - SHIFT: holds `shreg[7:0]` and `bitcnt[2:0]`.
  - `SerOut = shreg[7]`, `SerValid=1`.
- IDLE -> SHIFT: on an edge where `Level>0`. The FIFO is popped, `shreg` is loaded and `bitcnt` is set to 0.
- SHIFT, `bitcnt<7`: shift `shreg` left by 1 and increment `bitcnt`.
- SHIFT, `bitcnt==7` (last bit):
  - If `Level>0`: pop and load the next byte, `bitcnt=0`, stay in SHIFT. There is no gap.
  - Otherwise: go to IDLE.
- Simultaneous push and pop: `Level` is unchanged; pointers wrap modulo DEPTH.
- A push into an empty FIFO is not visible to the pop logic until the following edge.
- Push while full: ignored (`InReady=0`). Data is not corrupted.
- Reset (at any time, including mid-byte):
  - FIFO is emptied and the shifter returns to IDLE.
  - Any partial byte is discarded, not completed.
- `Busy = (state==SHIFT) || (Level!=0)`.

## Timing
- Reset values: `InReady=1`, `SerOut=0`, `SerValid=0`, `Busy=0`, `Level=0`.
- Edges are numbered from the push edge E0.
- Latency from push to first bit, with the shifter idle:
  - Push at E0 gives `Level=1` after E0.
  - The load occurs at E1, so the MSB is on `SerOut` after E1.
  - The LSB is on `SerOut` after E8. If no further byte is queued, the return to IDLE occurs at E9.
- Steady-state throughput: 1 bit/cycle, so 1 byte per 8 cycles, with no idle bit between queued bytes.
- All outputs are registered or derived from registered state only. There is no combinational path from `DataIn` or `InValid` to any output.

## Structure
- Shared package `seqdec_pkg`:
  - `BYTE_W=8`.
  - State enum `ser_state_t` with values {IDLE, SHIFT}.
  - Detector pattern constant `SEQ_PATTERN=8'h28`.
- Sub-module `seqdec_sync_fifo`:
  - Parameterized width and depth.
  - Ports: push, pop, full, empty, count.
  - Read/write pointers with an extra wrap bit.
- The top level contains the shifter FSM, `bitcnt` and the handshake glue.

## Test plan
- Reset check: assert `Reset` for 2 cycles. All outputs hold their reset values; `InReady=1`.
- Single byte: push 0x28 into an idle block. Starting after E1, `SerOut` = 0,0,1,0,1,0,0,0 with `SerValid=1` for exactly 8 cycles. IDLE follows. A connected `seqdec_28` `Out` asserts once.
- Back-to-back bytes: push 0x85, 0x97, 0x42, 0x53, 0x28 on consecutive cycles.
  - `SerValid` stays high for 40 contiguous cycles.
  - The bitstream equals 0x8597425328, MSB-first.
  - `InReady` drops when `Level` reaches 4.
- Full FIFO: hold `InValid=1` with 6 distinct bytes.
  - The 6th byte is stalled while `Level==4`.
  - It is accepted on the edge after `Level` falls to 3.
  - All 6 bytes are serialized in order with no loss or duplication.
- Reset mid-byte: assert `Reset` at the 4th bit of 0xA5 with 2 bytes queued.
  - After the next edge: `SerOut=0`, `SerValid=0`, `Level=0`.
  - No remaining bits of 0xA5 or the queued bytes appear.
- Wrap-around: push and serialize 3×DEPTH+1 bytes of an incrementing pattern. The serialized order matches, confirming correct pointer wrap.
